// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 16-bit unsigned multiply/divide unit.
// Shift-add multiply and restoring divide share one accumulator/shift-register
// pair and finish in 16 iterations, then raise a one-cycle write-back strobe
// that drives the register file write port directly.
module muldiv_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic [2:0]       dest,
  output logic             busy,
  output logic             wb_en,
  output logic [2:0]       wb_reg,
  output logic [WIDTH-1:0] wb_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t           r_state;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [2:0]       r_dest;
  logic [4:0]       r_cnt;
  // Accumulator: multiply high half / divide partial remainder. The 17th bit
  // of either algorithm is always zero between iterations (the multiply carry
  // is shifted down, the remainder stays below the divisor), so it exists only
  // as a carry/borrow inside the step logic below.
  logic [WIDTH-1:0] r_acc;
  // Shift register: multiply low half / divide quotient.
  logic [WIDTH-1:0] r_sh;
  logic             r_busy;
  logic             r_wb_en;
  logic [2:0]       r_wb_reg;
  logic [WIDTH-1:0] r_wb_data;

  logic             w_div0;
  logic             w_accept;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_sh_nxt;

  assign w_div0 = op[1] && (opb == '0);

  // Accept in IDLE, or on the exit edge of DONE so a held start reissues
  // every 17 cycles. A divide-by-zero seen in DONE waits for the IDLE edge,
  // otherwise its immediate strobe would abut the previous one.
  assign w_accept = start &&
                    ((r_state == S_IDLE) || ((r_state == S_DONE) && !w_div0));

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can leave it unassigned and infer a latch.
    w_acc_nxt = r_acc;
    w_sh_nxt  = r_sh;
    w_sum     = {1'b0, r_acc} + (r_sh[0] ? {1'b0, r_opa} : {(WIDTH+1){1'b0}});
    w_rem_sh  = {r_acc, r_sh[WIDTH-1]};
    w_trial   = w_rem_sh - {1'b0, r_opb};
    if (!r_op[1]) begin
      // Carry from the add lands in the top bit of the shifted high half.
      w_acc_nxt = w_sum[WIDTH:1];
      w_sh_nxt  = {w_sum[0], r_sh[WIDTH-1:1]};
    end else if (w_trial[WIDTH]) begin
      // Borrow out means the trial went negative: restore.
      w_acc_nxt = w_rem_sh[WIDTH-1:0];
      w_sh_nxt  = {r_sh[WIDTH-2:0], 1'b0};
    end else begin
      w_acc_nxt = w_trial[WIDTH-1:0];
      w_sh_nxt  = {r_sh[WIDTH-2:0], 1'b1};
    end
  end

  // Control FSM, datapath registers and registered write-back outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_opa     <= '0;
      r_opb     <= '0;
      r_dest    <= '0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_sh      <= '0;
      r_busy    <= 1'b0;
      r_wb_en   <= 1'b0;
      r_wb_reg  <= '0;
      r_wb_data <= '0;
    end else begin
      r_wb_en <= 1'b0;
      if (w_accept) begin
        r_op   <= op;
        r_opa  <= opa;
        r_opb  <= opb;
        r_dest <= dest;
        r_cnt  <= '0;
        r_acc  <= '0;
        r_sh   <= op[1] ? opa : opb;
        r_busy <= 1'b1;
        if (w_div0) begin
          r_state   <= S_DONE;
          r_wb_en   <= 1'b1;
          r_wb_reg  <= dest;
          r_wb_data <= op[0] ? opa : '1;
        end else begin
          r_state <= S_RUN;
        end
      end else begin
        case (r_state)
          S_RUN: begin
            r_acc <= w_acc_nxt;
            r_sh  <= w_sh_nxt;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd15) begin
              r_state   <= S_DONE;
              r_wb_en   <= 1'b1;
              r_wb_reg  <= r_dest;
              // op[0] picks the accumulator half (MULHI/REMU) or the shift
              // register half (MULLO/DIVU).
              r_wb_data <= r_op[0] ? w_acc_nxt : w_sh_nxt;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy    = r_busy;
  assign wb_en   = r_wb_en;
  assign wb_reg  = r_wb_reg;
  assign wb_data = r_wb_data;

endmodule
